// File: rtl/masked_stage2_random_source_pkg.sv
// Shared AES-128 masking definitions: random-width helpers, LFSR constants and
// the random-source state encoding.
package aes128_package;

    localparam logic [31:0] RNG_LFSR_POLY = 32'h8020_0003;

    // Stage-2 HPC1 inverse consumes 16 fresh random bits per share pair.
    function automatic int stage_2_hpc1_randoms(input int num_shares);
        return 8 * num_shares * (num_shares - 1);
    endfunction

    function automatic int rng_lanes(input int width);
        return (width + 31) / 32;
    endfunction

    function automatic logic [31:0] rng_lfsr_step(input logic [31:0] state);
        return state[0] ? ((state >> 1) ^ RNG_LFSR_POLY) : (state >> 1);
    endfunction

    typedef enum logic [2:0] {
        RNG_UNSEEDED,
        RNG_SEEDING,
        RNG_WARMUP,
`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
        RNG_RUN,
        RNG_ERROR
`else
        RNG_RUN
`endif
    } rng_state_t;

endpackage

// File: rtl/masked_stage2_random_source_if.sv
// Seed-load and mask-word handshake between the random source (master) and
// the stage-2 consumer / seeding logic (slave).
interface masked_stage2_random_source_if #(
    parameter int NUM_RANDOM = 16
);
    logic [31:0]           in_seed;
    logic                  in_seed_valid;
    logic                  out_seed_ready;
    logic                  in_enable;
    logic [NUM_RANDOM-1:0] out_random;
    logic                  out_valid;
    logic                  out_error;

    modport master (
        input  in_seed, in_seed_valid, in_enable,
        output out_seed_ready, out_random, out_valid, out_error
    );

    modport slave (
        output in_seed, in_seed_valid, in_enable,
        input  out_seed_ready, out_random, out_valid, out_error
    );
endinterface

// File: rtl/masked_stage2_random_source_lane.sv
// One seedable 32-bit Galois LFSR lane; an advance applies STEPS_PER_CYCLE
// unrolled right-shift steps. Only the low OUT_BITS of the state are exported.
module rng_lfsr_lane
    import aes128_package::*;
#(
    parameter int STEPS_PER_CYCLE = 8,
    parameter int OUT_BITS        = 32
) (
    input  logic                in_clock,
    input  logic                in_reset,
    input  logic                load,
    input  logic [31:0]         seed,
    input  logic                advance,
`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
    output logic                is_zero,
`endif
    output logic [OUT_BITS-1:0] value
);

    logic [31:0] state_q;
    logic [31:0] state_next;

    always_comb begin
        state_next = state_q;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            state_next = rng_lfsr_step(state_next);
        end
    end

    // A zero seed would lock the LFSR at zero forever, so it is replaced by 1.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= (seed == 32'h0) ? 32'h0000_0001 : seed;
        end else if (advance) begin
            state_q <= state_next;
        end
    end

    assign value = state_q[OUT_BITS-1:0];

`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
    assign is_zero = (state_q == 32'h0);
`endif

endmodule

// File: rtl/masked_stage2_random_source.sv
// Mask-word source for the HPC1 inverse stage 2: seeded LFSR lanes with warm-up
// and run/stall control. Health checking is built with MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN.
module masked_stage2_random_source
    import aes128_package::*;
#(
    parameter int NUM_SHARES      = 2,
    parameter int STEPS_PER_CYCLE = 8,
    parameter int WARMUP_CYCLES   = 16
) (
    input  logic                          in_clock,
    input  logic                          in_reset,
    masked_stage2_random_source_if.master rng
);

    localparam int NUM_RANDOM = stage_2_hpc1_randoms(NUM_SHARES);
    localparam int LANES      = rng_lanes(NUM_RANDOM);
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WARM_W     = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

    rng_state_t            state;
    logic [LANE_W-1:0]     lane_count;
    logic [WARM_W-1:0]     warm_count;
    logic                  valid_q;
    logic                  seed_accept;
    logic                  advance;
    logic [NUM_RANDOM-1:0] random_bus;

    // A seed offered in WARMUP or RUN is taken immediately and restarts seeding.
    assign seed_accept = rng.in_seed_valid &&
                         ((state == RNG_SEEDING) || (state == RNG_WARMUP) || (state == RNG_RUN));
    assign advance     = !seed_accept &&
                         ((state == RNG_WARMUP) || ((state == RNG_RUN) && rng.in_enable));

`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
    logic [LANES-1:0]      lane_zero;
    logic [NUM_RANDOM-1:0] prev_random;
    logic                  check_pending;
    logic                  health_fault;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int BITS = ((NUM_RANDOM - 32 * i) >= 32) ? 32 : (NUM_RANDOM - 32 * i);

        rng_lfsr_lane #(
            .STEPS_PER_CYCLE(STEPS_PER_CYCLE),
            .OUT_BITS       (BITS)
        ) u_lane (
            .in_clock(in_clock),
            .in_reset(in_reset),
            .load    (seed_accept && (lane_count == LANE_W'(i))),
            .seed    (rng.in_seed),
            .advance (advance),
`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
            .is_zero (lane_zero[i]),
`endif
            .value   (random_bus[32*i +: BITS])
        );
    end

`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
    // Remember the word taken on each RUN advance so a stuck generator shows up next cycle.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            prev_random   <= '0;
            check_pending <= 1'b0;
        end else begin
            check_pending <= (state == RNG_RUN) && advance;
            if (advance) begin
                prev_random <= random_bus;
            end
        end
    end

    assign health_fault = (|lane_zero) || (check_pending && (random_bus == prev_random));
`endif

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state      <= RNG_UNSEEDED;
            lane_count <= '0;
            warm_count <= '0;
            valid_q    <= 1'b0;
`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
            rng.out_error <= 1'b0;
`endif
        end else begin
            case (state)
                RNG_UNSEEDED: begin
                    if (rng.in_seed_valid) begin
                        state <= RNG_SEEDING;
                    end
                end
                RNG_SEEDING, RNG_WARMUP, RNG_RUN: begin
`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
                    if (health_fault && (state != RNG_SEEDING)) begin
                        state         <= RNG_ERROR;
                        rng.out_error <= 1'b1;
                        valid_q       <= 1'b0;
                    end else
`endif
                    if (seed_accept) begin
                        valid_q    <= 1'b0;
                        warm_count <= '0;
                        if (lane_count == LANE_LAST) begin
                            lane_count <= '0;
                            state      <= RNG_WARMUP;
                        end else begin
                            lane_count <= lane_count + 1'b1;
                            state      <= RNG_SEEDING;
                        end
                    end else if (state == RNG_WARMUP) begin
                        if (warm_count == WARM_LAST) begin
                            warm_count <= '0;
                            state      <= RNG_RUN;
                            valid_q    <= 1'b1;
                        end else begin
                            warm_count <= warm_count + 1'b1;
                        end
                    end
                end
`ifdef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
                RNG_ERROR: begin
                    if (rng.in_seed_valid) begin
                        state         <= RNG_SEEDING;
                        lane_count    <= '0;
                        rng.out_error <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= RNG_UNSEEDED;
                end
            endcase
        end
    end

    assign rng.out_seed_ready = seed_accept;
    assign rng.out_random     = random_bus;
    assign rng.out_valid      = valid_q;

`ifndef MASKED_STAGE2_RANDOM_SOURCE_HEALTH_EN
    assign rng.out_error = 1'b0;
`endif

endmodule

// File: tb/tb_masked_stage2_random_source.sv
// Bench for masked_stage2_random_source: a 2-share (one lane) and a 3-share
// (two lane) instance checked against a plain-arithmetic LFSR word model.
module tb_masked_stage2_random_source;

    localparam int R2 = 16;
    localparam int R3 = 48;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] m2;
    logic [31:0] m3 [2];

    always #5 clk = ~clk;

    masked_stage2_random_source_if #(.NUM_RANDOM(R2)) bus2 ();
    masked_stage2_random_source_if #(.NUM_RANDOM(R3)) bus3 ();

    masked_stage2_random_source #(
        .NUM_SHARES(2), .STEPS_PER_CYCLE(8), .WARMUP_CYCLES(16)
    ) dut2 (
        .in_clock(clk), .in_reset(rst_n), .rng(bus2)
    );

    masked_stage2_random_source #(
        .NUM_SHARES(3), .STEPS_PER_CYCLE(8), .WARMUP_CYCLES(16)
    ) dut3 (
        .in_clock(clk), .in_reset(rst_n), .rng(bus3)
    );

    // Reference word generator: eight Galois steps of x^32+x^22+x^2+x+1 per advance.
    function automatic logic [31:0] model_advance(input logic [31:0] s, input int n);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < n * 8; k++) begin
            if (r[0]) r = (r >> 1) ^ 32'h8020_0003;
            else      r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus2.in_seed = '0; bus2.in_seed_valid = 1'b0; bus2.in_enable = 1'b0;
        bus3.in_seed = '0; bus3.in_seed_valid = 1'b0; bus3.in_enable = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++;
            if (bus2.out_valid !== 1'b0 || bus2.out_seed_ready !== 1'b0 || bus2.out_random !== 16'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_idle2 cycle %0d: got valid=%b ready=%b random=%h want 0 0 0000",
                         i, bus2.out_valid, bus2.out_seed_ready, bus2.out_random);
            end
            n_checks++;
            if (bus3.out_valid !== 1'b0 || bus3.out_random !== 48'h0 || bus3.out_error !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_idle3 cycle %0d: got valid=%b random=%h error=%b want 0 0 0",
                         i, bus3.out_valid, bus3.out_random, bus3.out_error);
            end
        end
    endtask

    // Fresh seeding of the one-lane instance from UNSEEDED, then a run with enable held.
    task automatic test_single_lane(input logic [31:0] seed, input string tag);
        do_reset();
        bus2.in_seed = seed; bus2.in_seed_valid = 1'b1; bus2.in_enable = 1'b1;
        #1;
        n_checks++;
        if (bus2.out_seed_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_ready_unseeded: got %b want 0", tag, bus2.out_seed_ready);
        end
        tick();
        n_checks++;
        if (bus2.out_seed_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s_ready_seeding: got %b want 1", tag, bus2.out_seed_ready);
        end
        tick();
        bus2.in_seed_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (bus2.out_valid !== (k == 16)) begin
                n_fail++;
                $display("[TB] FAIL %s_valid_rise k=%0d: got %b want %b", tag, k, bus2.out_valid, (k == 16));
            end
        end
        m2 = model_advance(model_seed(seed), 16);
        n_checks++;
        if (bus2.out_random !== m2[15:0]) begin
            n_fail++;
            $display("[TB] FAIL %s_first_word: got %h want %h", tag, bus2.out_random, m2[15:0]);
        end
        for (int w = 0; w < 20; w++) begin
            tick();
            m2 = model_advance(m2, 1);
            n_checks++;
            if (bus2.out_random !== m2[15:0] || bus2.out_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL %s_word%0d: got %h valid=%b want %h valid=1",
                         tag, w, bus2.out_random, bus2.out_valid, m2[15:0]);
            end
        end
    endtask

    task automatic test_enable_toggle();
        logic [3:0] pattern;
        logic       e;
        pattern = 4'b1001;
        for (int c = 0; c < 28; c++) begin
            e = (c < 4) ? pattern[3 - c] : 1'($urandom_range(0, 1));
            bus2.in_enable = e;
            tick();
            if (e) m2 = model_advance(m2, 1);
            n_checks++;
            if (bus2.out_random !== m2[15:0] || bus2.out_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL enable_toggle c=%0d en=%b: got %h valid=%b want %h valid=1",
                         c, e, bus2.out_random, bus2.out_valid, m2[15:0]);
            end
        end
    endtask

    // Reseed of the one-lane instance while running: the accept goes straight to warm-up.
    task automatic test_back_to_back();
        logic [31:0] s;
        s = $urandom;
        bus2.in_seed = s; bus2.in_seed_valid = 1'b1; bus2.in_enable = 1'b1;
        #1;
        n_checks++;
        if (bus2.out_seed_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reseed1_ready: got %b want 1", bus2.out_seed_ready);
        end
        tick();
        bus2.in_seed_valid = 1'b0;
        m2 = model_seed(s);
        n_checks++;
        if (bus2.out_valid !== 1'b0 || bus2.out_random !== m2[15:0]) begin
            n_fail++;
            $display("[TB] FAIL reseed1_load: got valid=%b random=%h want valid=0 random=%h",
                     bus2.out_valid, bus2.out_random, m2[15:0]);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (bus2.out_valid !== (k == 16)) begin
                n_fail++;
                $display("[TB] FAIL reseed1_valid k=%0d: got %b want %b", k, bus2.out_valid, (k == 16));
            end
        end
        m2 = model_advance(m2, 16);
        n_checks++;
        if (bus2.out_random !== m2[15:0]) begin
            n_fail++;
            $display("[TB] FAIL reseed1_word: got %h want %h", bus2.out_random, m2[15:0]);
        end
        idle_inputs();
    endtask

    task automatic check_word3(input string tag);
        n_checks++;
        if (bus3.out_random !== {m3[1][15:0], m3[0]}) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h want %h", tag, bus3.out_random, {m3[1][15:0], m3[0]});
        end
    endtask

    task automatic run_random3(input int n);
        logic e;
        for (int c = 0; c < n; c++) begin
            e = 1'($urandom_range(0, 1));
            bus3.in_enable = e;
            tick();
            if (e) begin
                m3[0] = model_advance(m3[0], 1);
                m3[1] = model_advance(m3[1], 1);
            end
            check_word3("multi_run_word");
        end
    endtask

    task automatic warmup3(input string tag);
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (bus3.out_valid !== (k == 16)) begin
                n_fail++;
                $display("[TB] FAIL %s k=%0d: got %b want %b", tag, k, bus3.out_valid, (k == 16));
            end
        end
        m3[0] = model_advance(m3[0], 16);
        m3[1] = model_advance(m3[1], 16);
    endtask

    task automatic test_multi_lane();
        logic [31:0] sa, sb;
        do_reset();
        bus3.in_seed = 32'hDEAD_BEEF; bus3.in_seed_valid = 1'b1;
        #1;
        n_checks++;
        if (bus3.out_seed_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL multi_ready_unseeded: got %b want 0", bus3.out_seed_ready);
        end
        tick();
        n_checks++;
        if (bus3.out_seed_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL multi_ready_lane0: got %b want 1", bus3.out_seed_ready);
        end
        tick();
        bus3.in_seed = 32'h1234_5678;
        #1;
        n_checks++;
        if (bus3.out_seed_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL multi_ready_lane1: got %b want 1", bus3.out_seed_ready);
        end
        tick();
        bus3.in_seed_valid = 1'b0;
        #1;
        n_checks++;
        if (bus3.out_seed_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL multi_ready_drop: got %b want 0", bus3.out_seed_ready);
        end
        m3[0] = 32'hDEAD_BEEF;
        m3[1] = 32'h1234_5678;
        warmup3("multi_valid_rise");
        check_word3("multi_first_word");
        run_random3(12);

        sa = $urandom;
        sb = $urandom;
        bus3.in_seed = sa; bus3.in_seed_valid = 1'b1; bus3.in_enable = 1'b1;
        #1;
        n_checks++;
        if (bus3.out_seed_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL multi_reseed_ready: got %b want 1", bus3.out_seed_ready);
        end
        tick();
        m3[0] = model_seed(sa);
        n_checks++;
        if (bus3.out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL multi_reseed_valid_drop: got %b want 0", bus3.out_valid);
        end
        check_word3("multi_reseed_partial");
        bus3.in_seed = sb;
        tick();
        m3[1] = model_seed(sb);
        bus3.in_seed_valid = 1'b0;
        bus3.in_enable = 1'b0;
        warmup3("multi_reseed_valid_rise");
        check_word3("multi_reseed_first_word");
        run_random3(10);
    endtask

    // Reset in the middle of a reseed must abandon it and come back unseeded.
    task automatic test_reset_mid();
        bus3.in_seed = $urandom; bus3.in_seed_valid = 1'b1;
        tick();
        bus3.in_seed_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus3.out_valid !== 1'b0 || bus3.out_random !== 48'h0 || bus3.out_seed_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: got valid=%b random=%h ready=%b want 0 0 0",
                     bus3.out_valid, bus3.out_random, bus3.out_seed_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus3.in_seed_valid = 1'b1;
        #1;
        n_checks++;
        if (bus3.out_seed_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_unseeded: got ready=%b want 0", bus3.out_seed_ready);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_error_idle();
        n_checks++;
        if (bus2.out_error !== 1'b0 || bus3.out_error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL error_flag: got %b/%b want 0/0", bus2.out_error, bus3.out_error);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_lane(32'h0000_0001, "seed_one");
        test_single_lane(32'h0000_0000, "seed_zero");
        test_enable_toggle();
        test_back_to_back();
        test_multi_lane();
        test_reset_mid();
        test_error_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
